// File: rtl/alu_writeback_pkg.sv
// alu_writeback_pkg: shared ALU types, flag/condition encodings and op classification
package alu_writeback_pkg;
  typedef logic [31:0] t_reg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR, OP_SHL,
    OP_SHR, OP_MOV, OP_COMP, OP_BIT, OP_TEST
  } t_alu_op;
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } t_flags;
  typedef enum logic [3:0] {
    CC_AL, CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS,
    CC_VC, CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_NV
  } t_cond_code;
  function automatic logic alu_op_writes(t_alu_op op);
    return !(op inside {OP_COMP, OP_BIT, OP_TEST});
  endfunction
endpackage

// File: rtl/alu_writeback_cond_eval.sv
// alu_writeback_cond_eval: combinational branch condition check against status flags
module alu_writeback_cond_eval
  import alu_writeback_pkg::*;
(
  input  t_flags     flags,
  input  t_cond_code cond,
  output logic       cond_true
);
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_AL: cond_true = 1'b1;
      CC_EQ: cond_true = flags.z;
      CC_NE: cond_true = ~flags.z;
      CC_CS: cond_true = flags.c;
      CC_CC: cond_true = ~flags.c;
      CC_MI: cond_true = flags.n;
      CC_PL: cond_true = ~flags.n;
      CC_VS: cond_true = flags.v;
      CC_VC: cond_true = ~flags.v;
      CC_HI: cond_true = ~flags.c & ~flags.z;
      CC_LS: cond_true = flags.c | flags.z;
      CC_GE: cond_true = flags.n == flags.v;
      CC_LT: cond_true = flags.n != flags.v;
      CC_GT: cond_true = ~flags.z & (flags.n == flags.v);
      CC_LE: cond_true = flags.z | (flags.n != flags.v);
      CC_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: one-entry ALU result buffer driving the register-file write port and owning C/Z/N/V
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int         REG_INDEX_WIDTH = 4,
  parameter logic [3:0] FLAGS_RESET     = 4'b0000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  t_alu_op                    in_op,
  input  logic [REG_INDEX_WIDTH-1:0] in_dest,
  input  t_reg                       in_result,
  input  logic                       in_carry,
  input  logic                       in_zero,
  input  logic                       in_neg,
  input  logic                       in_over,
  input  logic                       flush,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [REG_INDEX_WIDTH-1:0] wr_index,
  output t_reg                       wr_data,
  output logic                       carry_flag,
  output logic [3:0]                 flags,
  input  logic [3:0]                 cond,
  output logic                       cond_true,
  output logic                       fwd_valid,
  output logic [REG_INDEX_WIDTH-1:0] fwd_index,
  output t_reg                       fwd_data
);
  logic                       full_q, full_d;
  logic [REG_INDEX_WIDTH-1:0] idx_q, idx_d;
  t_reg                       data_q, data_d;
  t_flags                     flags_q, flags_d;
  logic                       writes, retire, accept, load;
  always_comb begin
    writes   = alu_op_writes(in_op);
    wr_en    = full_q & ~flush;
    retire   = wr_en & wr_ready;
    in_ready = ~full_q | retire | ~writes;
    accept   = in_valid & in_ready & ~flush;
    load     = accept & writes;
    full_d   = flush ? 1'b0 : load ? 1'b1 : retire ? 1'b0 : full_q;
    idx_d    = load ? in_dest : idx_q;
    data_d   = load ? in_result : data_q;
    flags_d  = accept ? t_flags'({in_carry, in_zero, in_neg, in_over}) : flags_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      full_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      flags_q <= t_flags'(FLAGS_RESET);
    end else begin
      full_q  <= full_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  assign wr_index   = idx_q;
  assign wr_data    = data_q;
  assign carry_flag = flags_q.c;
  assign flags      = flags_q;
  assign fwd_valid  = full_q;
  assign fwd_index  = idx_q;
  assign fwd_data   = data_q;
  alu_writeback_cond_eval u_cond (
    .flags    (flags_q),
    .cond     (t_cond_code'(cond)),
    .cond_true(cond_true)
  );
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
Pipeline stage directly downstream of the ALU. It captures the ALU result and flags into a one-entry valid/ready buffer and owns the architectural status flags (C, Z, N, V). It drives the register-file write port and feeds the carry flag back to the ALU carry_in. It also evaluates branch condition codes from the committed flags and exposes the pending entry for operand forwarding.

Parameters:
REG_INDEX_WIDTH, 4, width of the destination register index.
FLAGS_RESET, 4'b0000, reset value of {C,Z,N,V}.

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  reset; asynchronous assert, active-low
in_valid  input  1  ALU output presents a completed op
in_ready  output  1  stage can accept this cycle
in_op  input  t_alu_op  op that produced the result
in_dest  input  REG_INDEX_WIDTH  destination register index
in_result  input  t_reg  ALU result
in_carry, in_zero, in_neg, in_over  input  1 each  ALU flag outputs
flush  input  1  discard pending and incoming entries
wr_en  output  1  register-file write request
wr_ready  input  1  register file accepts write (may be busy with load writeback)
wr_index  output  REG_INDEX_WIDTH  write index
wr_data  output  t_reg  write data
carry_flag  output  1  committed C flag, wired to ALU carry_in
flags  output  4  committed {C,Z,N,V}
cond  input  4  condition code to evaluate
cond_true  output  1  combinational result of cond against committed flags
fwd_valid  output  1  buffered entry will write a register
fwd_index  output  REG_INDEX_WIDTH  index of buffered entry
fwd_data  output  t_reg  data of buffered entry

Behaviour:
- Reset (async, reset_n=0): buffer empty, flags=FLAGS_RESET, wr_en=0, fwd_valid=0, wr_index=0, wr_data=0. in_ready=1 immediately after release.
- Accept: accept = in_valid & in_ready & ~flush. in_ready = ~full | (wr_en & wr_ready), so back-to-back throughput is 1/cycle.
- Flag commit: on the accept edge, all four flags load from in_* for every op, so an ADDC in the next cycle sees the new carry with zero bubbles. Flags are never rolled back by flush.
- Write suppression: OP_COMP, OP_BIT and OP_TEST update flags only. They occupy no buffer slot, are accepted even when full, and never assert wr_en.
- Buffer: on accept of a writing op, store {dest, result}. full asserts the next cycle.
- wr_en = full. An entry retires on wr_en & wr_ready. Retire and accept in the same cycle means the buffer reloads and full stays 1. wr_en holds while wr_ready=0, with wr_index and wr_data stable.
- fwd_* mirror the buffer. fwd_valid = full.
- Flush: clears full on the next edge, and the incoming op is not accepted (no flag update). If flush coincides with wr_ready, the write is still dropped (flush wins).
- Condition codes (C is borrow for SUB):
  - 0 always; 1 EQ Z; 2 NE ~Z; 3 CS C; 4 CC ~C; 5 MI N; 6 PL ~N; 7 VS V; 8 VC ~V.
  - 9 HI ~C&~Z; 10 LS C|Z; 11 GE N==V; 12 LT N!=V; 13 GT ~Z&(N==V); 14 LE Z|(N!=V); 15 never.
- Reset asserted mid-operation discards the buffer immediately; the write port deasserts asynchronously.

Decomposition:
- alu.vh gains t_flags (packed {C,Z,N,V}), t_cond_code with the 16 encodings above, and a function alu_op_writes(t_alu_op).
- registers.vh supplies t_reg and the index type.
- One natural sub-module, cond_eval: purely combinational, flags + cond -> cond_true, reused by the branch unit.

Test Plan:
- Reset: pulse reset_n low while in_valid=1 -> wr_en=0, flags=0000, in_ready=1, cond=15 gives 0, cond=0 gives 1.
- ADD result 0x00000000 with C=1, Z=1, dest 3, wr_ready=1 -> next cycle wr_en=1, wr_index=3, wr_data=0; flags=1100; carry_flag=1; cond EQ=1, CS=1.
- Back-to-back: SUB 1-2 (0xffffffff, C=1, N=1) then SUBC, wr_ready=1 -> two consecutive wr_en cycles; flags=1010 after the first, CS=1 and LT=1 (N!=V).
- Stall: two writing ops with wr_ready=0 for 3 cycles -> the first is held stable and in_ready=0; the second is accepted on the cycle wr_ready rises; wr_data order is preserved.
- COMP 1,2 (C=1, N=1) while buffer full and stalled -> in_ready=1, flags update to 1010, buffer contents unchanged, no extra write.
- Flush with full=1 and in_valid=1 -> no write occurs, fwd_valid=0 next cycle, flags retain the previously committed value.
